shift_mix_stage: RTL and testbench

SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

---
 rtl/shift_mix_stage.sv | 143 ++++++++++++++
 tb/tb_shift_mix_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_mix_stage.sv
// One AES round stage: ShiftRows then MixColumns (MixColumns skipped on the last round), result registered.
// Define SHIFT_MIX_SKID_EN to add a skid register so that in_ready is registered instead of combinational.
module shift_mix_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned W = 128;

  logic [W-1:0] xf;
  logic [W-1:0] out_n;
  logic         out_valid_n;
  logic         accept;
  logic         deliver;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte s(r,c) sits at bit offset 8*(15-(4c+r)).
  function automatic logic [7:0] get_byte(input logic [W-1:0] s, input int r, input int c);
    return s[8*(15-(4*c+r)) +: 8];
  endfunction

  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = get_byte(s, r, (c + r) % 4);
    return o;
  endfunction

  function automatic logic [W-1:0] mix_columns(input logic [W-1:0] s);
    logic [W-1:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 0, c);
      a1 = get_byte(s, 1, c);
      a2 = get_byte(s, 2, c);
      a3 = get_byte(s, 3, c);
      o[8*(15-4*c) +: 8]       = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(15-(4*c+1)) +: 8]   = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
      o[8*(15-(4*c+2)) +: 8]   = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
      o[8*(15-(4*c+3)) +: 8]   = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;
    end
    return o;
  endfunction

  // Round transform on the input side; only the registered copy reaches out.
  always_comb begin
    xf = shift_rows(in);
    if (!in_last)
      xf = mix_columns(xf);
  end

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

`ifdef SHIFT_MIX_SKID_EN
  logic [W-1:0] skid;
  logic [W-1:0] skid_n;
  logic         skid_valid;
  logic         skid_valid_n;
  logic         ready_q;

  assign in_ready = ready_q && !rst;

  // A block arriving while out is stalled parks in skid; skid refills out on delivery.
  always_comb begin
    out_n        = out;
    out_valid_n  = out_valid;
    skid_n       = skid;
    skid_valid_n = skid_valid;
    if (deliver) begin
      if (skid_valid) begin
        out_n        = skid;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_n = xf;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (out_valid) begin
        skid_n       = xf;
        skid_valid_n = 1'b1;
      end else begin
        out_n       = xf;
        out_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      out_valid  <= 1'b0;
      skid       <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      out        <= out_n;
      out_valid  <= out_valid_n;
      skid       <= skid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= !skid_valid_n;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  always_comb begin
    out_n       = out;
    out_valid_n = out_valid;
    if (accept) begin
      out_n       = xf;
      out_valid_n = 1'b1;
    end else if (deliver) begin
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= out_n;
      out_valid <= out_valid_n;
    end
  end
`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// Randomized and directed bench for shift_mix_stage against a byte-array AES round model.
// Honours SHIFT_MIX_SKID_EN for the variant-specific backpressure expectations.
module tb_shift_mix_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb[$];

`ifdef SHIFT_MIX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  shift_mix_stage dut (
    .clk(clk), .rst(rst), .in(in), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply by shift-and-add with 0x11B reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic last);
    logic [7:0] s[4][4];
    logic [7:0] t[4][4];
    logic [7:0] o[4][4];
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) s[k % 4][k / 4] = d[127 - 8*k -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) t[row][col] = s[row][(col + row) % 4];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        o[row][col] = last ? t[row][col] :
          gmul(8'h02, t[row][col]) ^ gmul(8'h03, t[(row+1)%4][col]) ^
          t[(row+2)%4][col] ^ t[(row+3)%4][col];
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k % 4][k / 4];
    return r;
  endfunction

  // One clock: scoreboard the handshakes seen before the edge, then return just after it.
  task automatic tick();
    logic acc, del, rs;
    @(negedge clk);
    rs  = rst;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (!rs) begin
      if (del) begin
        if (sb.size() == 0) check("spurious_out", 128'(out_valid), 128'(0));
        else check("sb_out", out, sb.pop_front());
      end
      if (acc) sb.push_back(ref_round(in, in_last));
    end
    @(posedge clk);
    #1;
    if (rs) sb.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("drain_empty", 128'(sb.size()), 128'(0));
    check("drain_valid", 128'(out_valid), 128'(0));
  endtask

  logic [127:0] a_blk, b_blk, exp_a, exp_b, prev_out;
  logic         prev_stall;
  int           n_acc;

  initial begin
    rst = 1'b1; in = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    repeat (2) tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out", out, 128'h0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 round 1 vector, then same state as a last round, then GF boundary.
    in = 128'hd42711aee0bf98f1b8b45de51e415230; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("fips_valid", 128'(out_valid), 128'(1));
    check("fips_mix", out, 128'h046681e5e0cb199a48f8d37a2806264c);
    in_last = 1'b1;
    tick();
    check("fips_last", out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    in = {16{8'h80}}; in_last = 1'b0;
    tick();
    check("gf_80", out, {16{8'h80}});
    drain();

    // Backpressure: A stalls in out for 5 cycles while B is offered.
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    b_blk = {$urandom, $urandom, $urandom, $urandom};
    exp_a = ref_round(a_blk, 1'b0);
    exp_b = ref_round(b_blk, 1'b1);
    in = a_blk; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in = b_blk; in_last = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef SHIFT_MIX_SKID_EN
      check("bp_in_ready", 128'(in_ready), 128'(i == 0));
`else
      check("bp_in_ready", 128'(in_ready), 128'(0));
`endif
      if (in_valid && in_ready) n_acc++;
      tick();
      check("bp_hold", out, exp_a);
      check("bp_valid", 128'(out_valid), 128'(1));
`ifdef SHIFT_MIX_SKID_EN
      if (i == 0) in_valid = 1'b0;
`endif
    end
`ifdef SHIFT_MIX_SKID_EN
    check("bp_b_once", 128'(n_acc), 128'(1));
`else
    check("bp_b_none", 128'(n_acc), 128'(0));
`endif
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_b_next", out, exp_b);
    tick();
    drain();

    // Streaming: 16 back-to-back blocks, one result per cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      in_last = 1'($urandom_range(0, 1));
      #1;
      check("stream_ready", 128'(in_ready), 128'(1));
      tick();
      check("stream_valid", 128'(out_valid), 128'(1));
    end
    drain();

    // Random traffic with hold and occupancy checks.
    prev_stall = 1'b0; prev_out = '0;
    for (int i = 0; i < 300; i++) begin
      in        = {$urandom, $urandom, $urandom, $urandom};
      in_last   = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      tick();
      if (prev_stall) check("rand_hold", out, prev_out);
      check("rand_occupancy", 128'(sb.size() <= CAP), 128'(1));
    end
    drain();

    // Reset with blocks held (2 in the skid build, 1 otherwise).
    in = {$urandom, $urandom, $urandom, $urandom}; in_last = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) tick();
    check("pre_rst_held", 128'(sb.size()), 128'(CAP));
    rst = 1'b1;
    in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    tick();
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out", out, 128'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_ready", 128'(in_ready), 128'(1));
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    in = a_blk; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 128'(out_valid), 128'(1));
    check("post_rst_out", out, ref_round(a_blk, 1'b1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
